// File: rtl/mux_scan_collector.sv
// Scans a dual 1-of-4 mux through indices 0..3, samples B0/B1 after a settle
// delay and presents the two assembled 4-bit words under a valid/ack handshake.
module mux_scan_collector #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ack,
    input  logic       B0,
    input  logic       B1,
    output logic [0:1] SEL,
    output logic       EN,
    output logic [0:3] W0,
    output logic [0:3] W1,
    output logic       valid,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD
    } state_t;

    // With no settle time each index goes straight to its sample cycle.
    localparam state_t SCAN_FIRST = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:1]       sel_q, sel_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [0:3]       w0_q, w0_d;
    logic [0:3]       w1_q, w1_d;
    logic [0:3]       sh0_q, sh0_d;
    logic [0:3]       sh1_q, sh1_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            w0_q    <= '0;
            w1_q    <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = '0;
                    cnt_d   = SETTLE_C;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SCAN_FIRST;
                end
            end
            S_SETTLE: begin
                if (start) ovr_d = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (start) ovr_d = 1'b1;
                sh0_d[sel_q] = B0;
                sh1_d[sel_q] = B1;
                if (sel_q == 2'd3) begin
                    // Publish only complete scans; includes the bit taken this edge.
                    w0_d    = sh0_d;
                    w1_d    = sh1_d;
                    valid_d = 1'b1;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    sel_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    sel_d   = sel_q + 2'd1;
                    cnt_d   = SETTLE_C;
                    state_d = SCAN_FIRST;
                end
            end
            S_HOLD: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    if (start) begin
                        sel_d   = '0;
                        cnt_d   = SETTLE_C;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = SCAN_FIRST;
                    end
                end else if (start) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign SEL     = sel_q;
    assign EN      = en_q;
    assign W0      = w0_q;
    assign W1      = w1_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_mux_scan_collector.sv
// Bench for mux_scan_collector: two instances (settle 1 and settle 0) checked
// every cycle against a timeline model, plus literal spot checks.
module tb_mux_scan_collector;

    localparam int unsigned S0 = 1;
    localparam int unsigned S1 = 0;

    logic       clk;
    logic       reset;
    logic       st  [2];
    logic       ak  [2];
    logic       b0  [2];
    logic       b1  [2];
    logic [0:1] sel [2];
    logic       en  [2];
    logic [0:3] w0  [2];
    logic [0:3] w1  [2];
    logic       vld [2];
    logic       bsy [2];
    logic       ovr [2];
    logic [0:3] d0  [2];
    logic [0:3] d1  [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    mux_scan_collector #(.SETTLE(S0)) u_dut0 (
        .clk(clk), .reset(reset), .start(st[0]), .ack(ak[0]), .B0(b0[0]), .B1(b1[0]),
        .SEL(sel[0]), .EN(en[0]), .W0(w0[0]), .W1(w1[0]), .valid(vld[0]),
        .busy(bsy[0]), .overrun(ovr[0])
    );

    mux_scan_collector #(.SETTLE(S1)) u_dut1 (
        .clk(clk), .reset(reset), .start(st[1]), .ack(ak[1]), .B0(b0[1]), .B1(b1[1]),
        .SEL(sel[1]), .EN(en[1]), .W0(w0[1]), .W1(w1[1]), .valid(vld[1]),
        .busy(bsy[1]), .overrun(ovr[1])
    );

    // Mux model: selected data bit when enabled, else 0.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            b0[i] = en[i] ? d0[i][sel[i]] : 1'b0;
            b1[i] = en[i] ? d1[i][sel[i]] : 1'b0;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pos counts cycles into a scan (-1 when not scanning).
    int         m_pos [2];
    logic       m_val [2];
    logic       m_ovr [2];
    logic [0:3] m_w0  [2];
    logic [0:3] m_w1  [2];
    logic [0:3] m_sh0 [2];
    logic [0:3] m_sh1 [2];

    function automatic int per_idx(input int i);
        return (i == 0) ? int'(S0) + 1 : int'(S1) + 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            automatic int         p  = m_pos[i];
            automatic int         l  = per_idx(i);
            automatic logic       v  = m_val[i];
            automatic logic       o  = m_ovr[i];
            automatic logic [0:3] s0 = m_sh0[i];
            automatic logic [0:3] s1 = m_sh1[i];
            automatic logic [0:3] x0 = m_w0[i];
            automatic logic [0:3] x1 = m_w1[i];
            if (reset) begin
                p = -1; v = 1'b0; o = 1'b0; x0 = '0; x1 = '0; s0 = '0; s1 = '0;
            end else if (p >= 0) begin
                if (st[i]) o = 1'b1;
                if (p % l == l - 1) begin
                    s0[p / l] = d0[i][p / l];
                    s1[p / l] = d1[i][p / l];
                end
                p = p + 1;
                if (p == 4 * l) begin
                    p = -1; v = 1'b1; x0 = s0; x1 = s1;
                end
            end else if (v) begin
                if (ak[i]) begin
                    v = 1'b0;
                    if (st[i]) p = 0;
                end else if (st[i]) begin
                    o = 1'b1;
                end
            end else if (st[i]) begin
                p = 0;
            end
            m_pos[i] <= p;
            m_val[i] <= v;
            m_ovr[i] <= o;
            m_sh0[i] <= s0;
            m_sh1[i] <= s1;
            m_w0[i]  <= x0;
            m_w1[i]  <= x1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                automatic logic       e_b = (m_pos[i] >= 0);
                automatic logic [1:0] e_s = e_b ? 2'(m_pos[i] / per_idx(i)) : 2'd0;
                chk($sformatf("u%0d SEL", i),     32'(sel[i]), 32'(e_s));
                chk($sformatf("u%0d EN", i),      32'(en[i]),  32'(e_b));
                chk($sformatf("u%0d busy", i),    32'(bsy[i]), 32'(e_b));
                chk($sformatf("u%0d valid", i),   32'(vld[i]), 32'(m_val[i]));
                chk($sformatf("u%0d overrun", i), 32'(ovr[i]), 32'(m_ovr[i]));
                chk($sformatf("u%0d W0", i),      32'(w0[i]),  32'(m_w0[i]));
                chk($sformatf("u%0d W1", i),      32'(w1[i]),  32'(m_w1[i]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ak[i] = 1'b0; d0[i] = '0; d1[i] = '0;
        end

        // Asynchronous reset mid-cycle, no edge needed
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst SEL", 32'(sel[0]), 32'd0);
        chk("rst EN", 32'(en[0]), 32'd0);
        chk("rst W0", 32'(w0[0]), 32'd0);
        chk("rst W1", 32'(w1[0]), 32'd0);
        chk("rst valid", 32'(vld[0]), 32'd0);
        chk("rst busy", 32'(bsy[0]), 32'd0);
        chk("rst overrun", 32'(ovr[0]), 32'd0);
        chk_en = 1;
        tick();
        reset = 1'b0;
        tick();

        // Basic scan with settle 1
        d0[0] = 4'b1010; d1[0] = 4'b0110;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk("scan SEL seq", 32'(sel[0]), 32'(j / 2));
            chk("scan EN", 32'(en[0]), 32'd1);
            if (j < 7) tick();
        end
        chk("scan valid early", 32'(vld[0]), 32'd0);
        tick();
        chk("scan valid", 32'(vld[0]), 32'd1);
        chk("scan W0", 32'(w0[0]), 32'b1010);
        chk("scan W1", 32'(w1[0]), 32'b0110);
        chk("scan EN off", 32'(en[0]), 32'd0);

        // Hold without ack, then ack
        repeat (5) tick();
        chk("hold valid", 32'(vld[0]), 32'd1);
        chk("hold W0", 32'(w0[0]), 32'b1010);
        ak[0] = 1'b1;
        tick();
        ak[0] = 1'b0;
        chk("ack valid", 32'(vld[0]), 32'd0);

        // Ack together with start: old words kept until new scan lands
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (8) tick();
        chk("rescan valid", 32'(vld[0]), 32'd1);
        d0[0] = 4'b0011; d1[0] = 4'b1100;
        ak[0] = 1'b1; st[0] = 1'b1;
        tick();
        ak[0] = 1'b0; st[0] = 1'b0;
        chk("ackstart valid", 32'(vld[0]), 32'd0);
        chk("ackstart busy", 32'(bsy[0]), 32'd1);
        chk("ackstart W0 old", 32'(w0[0]), 32'b1010);
        repeat (7) tick();
        chk("ackstart W0 still old", 32'(w0[0]), 32'b1010);
        tick();
        chk("ackstart new W0", 32'(w0[0]), 32'b0011);
        chk("ackstart new W1", 32'(w1[0]), 32'b1100);
        chk("ackstart new valid", 32'(vld[0]), 32'd1);

        // Dropped starts set sticky overrun
        d0[0] = 4'b1010; d1[0] = 4'b0110;
        ak[0] = 1'b1;
        tick();
        ak[0] = 1'b0;
        chk("ovr clear", 32'(ovr[0]), 32'd0);
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (2) tick();
        chk("ovr at SEL1", 32'(sel[0]), 32'd1);
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        chk("ovr busy start", 32'(ovr[0]), 32'd1);
        repeat (5) tick();
        chk("ovr result valid", 32'(vld[0]), 32'd1);
        chk("ovr result W0", 32'(w0[0]), 32'b1010);
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        chk("ovr hold W0", 32'(w0[0]), 32'b1010);
        chk("ovr hold valid", 32'(vld[0]), 32'd1);
        ak[0] = 1'b1;
        tick();
        ak[0] = 1'b0;
        chk("ovr sticky", 32'(ovr[0]), 32'd1);
        chk("ovr ack valid", 32'(vld[0]), 32'd0);

        // Reset mid-scan, then a clean scan
        d0[0] = 4'b1111;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (4) tick();
        chk("midrst SEL2", 32'(sel[0]), 32'd2);
        #3 reset = 1'b1;
        #1;
        chk("midrst W0", 32'(w0[0]), 32'd0);
        chk("midrst valid", 32'(vld[0]), 32'd0);
        chk("midrst busy", 32'(bsy[0]), 32'd0);
        chk("midrst SEL", 32'(sel[0]), 32'd0);
        chk("midrst overrun", 32'(ovr[0]), 32'd0);
        tick();
        reset = 1'b0;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (8) tick();
        chk("postrst valid", 32'(vld[0]), 32'd1);
        chk("postrst W0", 32'(w0[0]), 32'b1111);

        // Zero settle on the second instance
        d0[1] = 4'b0001; d1[1] = 4'b1000;
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("s0 SEL seq", 32'(sel[1]), 32'(j));
            if (j < 3) tick();
        end
        tick();
        chk("s0 valid", 32'(vld[1]), 32'd1);
        chk("s0 W0", 32'(w0[1]), 32'b0001);
        chk("s0 W1", 32'(w1[1]), 32'b1000);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
